// File: rtl/instr_seq_ctrl_if.sv
// Handshake/strobe bundle between the instruction sequencer and the datapath.
// The master modport is the sequencer's view; the slave modport is the
// datapath's view (fetch stage, register file, ALU, flags, data memory).
interface instr_seq_ctrl_if #(
  parameter int CNT_W = 16
);
  // Datapath -> sequencer
  logic             halt;
  logic [31:0]      IR;
  logic             ir_valid;
  logic             mem_ready;
  // Sequencer -> datapath
  logic             write_ir;
  logic             write_pc;
  logic             pc_load;
  logic             write_a;
  logic             write_b;
  logic [3:0]       alu_op;
  logic             write_f;
  logic             write_nzcv;
  logic             write_reg;
  logic             rd_src_mem;
  logic             write_lr;
  logic             mem_read;
  logic             mem_write;
  logic             instr_done;
  logic             illegal;
  logic             mem_err;
  logic [CNT_W-1:0] ret_cnt;
  logic [3:0]       state_o;

  modport master (
    input  halt, IR, ir_valid, mem_ready,
    output write_ir, write_pc, pc_load, write_a, write_b, alu_op, write_f,
           write_nzcv, write_reg, rd_src_mem, write_lr, mem_read, mem_write,
           instr_done, illegal, mem_err, ret_cnt, state_o
  );

  modport slave (
    output halt, IR, ir_valid, mem_ready,
    input  write_ir, write_pc, pc_load, write_a, write_b, alu_op, write_f,
           write_nzcv, write_reg, rd_src_mem, write_lr, mem_read, mem_write,
           instr_done, illegal, mem_err, ret_cnt, state_o
  );
endinterface

// File: rtl/instr_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer. Moore strobes are decoded from
// the current state (plus IR fields where the strobe depends on the encoding).
// Optional build macro CTRL_MEM_WAIT_EN: MEM_RD/MEM_WR stall on mem_ready and
// abort with a sticky mem_err after WAIT_MAX consecutive not-ready cycles.
module instr_seq_ctrl #(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  instr_seq_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC     = 4'd3,
    S_WB       = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);

  state_t           state, next_state;
  logic             illegal_q, mem_err_q;
  logic [CNT_W-1:0] ret_cnt_q;

  // IR fields
  logic [1:0] ir_class;
  logic [3:0] opcode;
  logic       bit_s_l, bit_u, bit_link;
  assign ir_class = bus.IR[27:26];
  assign opcode   = bus.IR[24:21];
  assign bit_s_l  = bus.IR[20];
  assign bit_u    = bus.IR[23];
  assign bit_link = bus.IR[24];

  // Condition, immediate and register fields belong to the fetch stage/datapath.
  logic unused_ir;
  assign unused_ir = ^{bus.IR[31:28], bus.IR[25], bus.IR[19:0]};

  // Memory wait qualifiers: stall keeps MEM_RD/MEM_WR, timeout aborts them.
  logic mem_stall, mem_timeout;
`ifdef CTRL_MEM_WAIT_EN
  logic [WAIT_W-1:0] wait_cnt;
  logic              at_limit;
  assign at_limit    = (wait_cnt == WAIT_W'(WAIT_MAX - 1));
  assign mem_stall   = !bus.mem_ready && !at_limit;
  assign mem_timeout = !bus.mem_ready && at_limit;

  // Count consecutive not-ready cycles in a memory state; clear on exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if ((state == S_MEM_RD || state == S_MEM_WR) && mem_stall) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  assign mem_stall   = 1'b0;
  assign mem_timeout = 1'b0;
  logic unused_cfg;
  assign unused_cfg = bus.mem_ready ^ (WAIT_W == 0);
`endif

  // Strobe and next-state decode.
  logic       s_write_ir, s_write_pc, s_pc_load, s_write_a, s_write_b;
  logic       s_write_f, s_write_nzcv, s_write_reg, s_rd_src_mem, s_write_lr;
  logic       s_mem_read, s_mem_write, s_done, set_illegal, set_mem_err;
  logic [3:0] s_alu_op;
  state_t     boundary;

  assign boundary = bus.halt ? S_IDLE : S_FETCH;

  // Next state and Moore strobes for the current state.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    next_state   = state;
    s_write_ir   = 1'b0;
    s_write_pc   = 1'b0;
    s_pc_load    = 1'b0;
    s_write_a    = 1'b0;
    s_write_b    = 1'b0;
    s_alu_op     = 4'h0;
    s_write_f    = 1'b0;
    s_write_nzcv = 1'b0;
    s_write_reg  = 1'b0;
    s_rd_src_mem = 1'b0;
    s_write_lr   = 1'b0;
    s_mem_read   = 1'b0;
    s_mem_write  = 1'b0;
    s_done       = 1'b0;
    set_illegal  = 1'b0;
    set_mem_err  = 1'b0;
    unique case (state)
      S_IDLE:     next_state = boundary;
      S_FETCH: begin
        s_write_ir = 1'b1;
        s_write_pc = 1'b1;
        if (bus.ir_valid)  next_state = S_DECODE;
        else if (bus.halt) next_state = S_IDLE;
      end
      S_DECODE: begin
        s_write_a = 1'b1;
        s_write_b = 1'b1;
        unique case (ir_class)
          2'b00: next_state = S_EXEC;
          2'b01: next_state = S_MEM_ADDR;
          2'b10: next_state = S_BRANCH;
          2'b11: begin
            set_illegal = 1'b1;
            next_state  = boundary;
          end
        endcase
      end
      S_EXEC: begin
        s_alu_op     = opcode;
        s_write_f    = 1'b1;
        s_write_nzcv = bit_s_l;
        if (opcode[3:2] == 2'b10) s_done     = 1'b1;
        else                      next_state = S_WB;
      end
      S_WB: begin
        s_write_reg = 1'b1;
        s_done      = 1'b1;
      end
      S_MEM_ADDR: begin
        s_alu_op   = bit_u ? 4'h4 : 4'h2;
        s_write_f  = 1'b1;
        next_state = bit_s_l ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        s_mem_read = 1'b1;
        if (mem_timeout) begin
          set_mem_err = 1'b1;
          s_done      = 1'b1;
        end else if (!mem_stall) begin
          next_state = S_MEM_WB;
        end
      end
      S_MEM_WB: begin
        s_write_reg  = 1'b1;
        s_rd_src_mem = 1'b1;
        s_done       = 1'b1;
      end
      S_MEM_WR: begin
        s_mem_write = 1'b1;
        set_mem_err = mem_timeout;
        s_done      = !mem_stall;
      end
      S_BRANCH: begin
        s_pc_load  = 1'b1;
        s_write_lr = bit_link;
        s_done     = 1'b1;
      end
      default:    next_state = S_IDLE;
    endcase
    if (s_done) next_state = boundary;
  end

  // State register, sticky error flags and retired-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
      ret_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= next_state;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_mem_err) mem_err_q <= 1'b1;
      if (s_done)      ret_cnt_q <= ret_cnt_q + CNT_W'(1);
    end
  end

  assign bus.write_ir   = s_write_ir;
  assign bus.write_pc   = s_write_pc;
  assign bus.pc_load    = s_pc_load;
  assign bus.write_a    = s_write_a;
  assign bus.write_b    = s_write_b;
  assign bus.alu_op     = s_alu_op;
  assign bus.write_f    = s_write_f;
  assign bus.write_nzcv = s_write_nzcv;
  assign bus.write_reg  = s_write_reg;
  assign bus.rd_src_mem = s_rd_src_mem;
  assign bus.write_lr   = s_write_lr;
  assign bus.mem_read   = s_mem_read;
  assign bus.mem_write  = s_mem_write;
  assign bus.instr_done = s_done;
  assign bus.illegal    = illegal_q;
  assign bus.mem_err    = mem_err_q;
  assign bus.ret_cnt    = ret_cnt_q;
  assign bus.state_o    = state;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Self-checking bench for instr_seq_ctrl: a table of per-cycle vectors
// {inputs, expected outputs}; expected records are queued when a row is driven
// and popped/compared by a negedge monitor. Hand-written sequences cover
// asynchronous reset mid-instruction and ret_cnt wrap on a narrow instance.
module tb_instr_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst4 = 1'b1;
  always #5 clk = ~clk;

  instr_seq_ctrl_if #(.CNT_W(16)) bus ();
  instr_seq_ctrl_if #(.CNT_W(4))  bus4 ();

  instr_seq_ctrl #(.CNT_W(16), .WAIT_MAX(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  instr_seq_ctrl #(.CNT_W(4), .WAIT_MAX(15)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4)
  );

  // Instruction encodings
  localparam logic [31:0] I_ADD  = 32'hE0810002;
  localparam logic [31:0] I_ADDS = 32'hE0910002;
  localparam logic [31:0] I_CMP  = 32'hE1500001;
  localparam logic [31:0] I_LDR  = 32'hE5910000;
  localparam logic [31:0] I_STR  = 32'hE5010000;
  localparam logic [31:0] I_B    = 32'hEA000000;
  localparam logic [31:0] I_BL   = 32'hEB000000;
  localparam logic [31:0] I_ILL  = 32'hEC000000;

  // Strobe vector bit order: write_ir write_pc pc_load write_a write_b write_f
  // write_nzcv write_reg rd_src_mem write_lr mem_read mem_write instr_done
  localparam logic [12:0] X_NONE  = 13'h0000;
  localparam logic [12:0] X_FETCH = 13'h1800;
  localparam logic [12:0] X_DEC   = 13'h0300;
  localparam logic [12:0] X_EXEC  = 13'h0080;
  localparam logic [12:0] X_EXECS = 13'h00C0;
  localparam logic [12:0] X_CMPS  = 13'h00C1;
  localparam logic [12:0] X_WB    = 13'h0021;
  localparam logic [12:0] X_MADDR = 13'h0080;
  localparam logic [12:0] X_MRD   = 13'h0004;
  localparam logic [12:0] X_MRDTO = 13'h0005;
  localparam logic [12:0] X_MWB   = 13'h0031;
  localparam logic [12:0] X_MWRW  = 13'h0002;
  localparam logic [12:0] X_MWR   = 13'h0003;
  localparam logic [12:0] X_B     = 13'h0401;
  localparam logic [12:0] X_BL    = 13'h0409;

  typedef struct packed {
    logic [3:0]  st;
    logic [12:0] stb;
    logic [3:0]  alu;
    logic        ill;
    logic        err;
    logic [15:0] cnt;
  } obs_t;

  typedef struct {
    logic        halt;
    logic [31:0] ir;
    logic        v;
    logic        mr;
    obs_t        exp;
  } vec_t;

  vec_t tbl[$];
  obs_t sb_q[$];
  int   id_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic add(input logic halt, input logic [31:0] ir, input logic v,
                     input logic mr, input logic [3:0] st, input logic [12:0] stb,
                     input logic [3:0] alu, input logic ill, input logic err,
                     input logic [15:0] cnt);
    vec_t r;
    r.halt = halt; r.ir = ir; r.v = v; r.mr = mr;
    r.exp  = '{st: st, stb: stb, alu: alu, ill: ill, err: err, cnt: cnt};
    tbl.push_back(r);
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.st  = bus.state_o;
    o.stb = {bus.write_ir, bus.write_pc, bus.pc_load, bus.write_a, bus.write_b,
             bus.write_f, bus.write_nzcv, bus.write_reg, bus.rd_src_mem,
             bus.write_lr, bus.mem_read, bus.mem_write, bus.instr_done};
    o.alu = bus.alu_op;
    o.ill = bus.illegal;
    o.err = bus.mem_err;
    o.cnt = bus.ret_cnt;
    return o;
  endfunction

  task automatic check(input int id, input obs_t act, input obs_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL vec%0d: got st=%0d stb=%h alu=%h ill=%b err=%b cnt=%0d | want st=%0d stb=%h alu=%h ill=%b err=%b cnt=%0d",
               id, act.st, act.stb, act.alu, act.ill, act.err, act.cnt,
               exp.st, exp.stb, exp.alu, exp.ill, exp.err, exp.cnt);
    end
  endtask

  task automatic check_val(input int id, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL chk%0d: got %0d want %0d", id, act, exp);
    end
  endtask

  // Drive one table row just after the active edge and queue its expectation.
  task automatic apply(input vec_t r, input int id);
    @(posedge clk);
    #1;
    bus.halt      = r.halt;
    bus.IR        = r.ir;
    bus.ir_valid  = r.v;
    bus.mem_ready = r.mr;
    sb_q.push_back(r.exp);
    id_q.push_back(id);
  endtask

  // Scoreboard monitor: compare queued expectations mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      obs_t e;
      int   id;
      e  = sb_q.pop_front();
      id = id_q.pop_front();
      check(id, sample(), e);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t zero;
    logic [15:0] c0;
    logic        e0;
    bit          seen;
    zero = '0;

    // ---- Vector table (one row per clock cycle) ----
    add(1, I_ADD, 0, 1, 0, X_NONE,  0, 0, 0, 0);   // IDLE, halt held
    add(0, I_ADD, 0, 1, 0, X_NONE,  0, 0, 0, 0);   // IDLE, release halt
    add(0, I_ADD, 1, 1, 1, X_FETCH, 0, 0, 0, 0);   // ADD
    add(0, I_ADD, 1, 1, 2, X_DEC,   0, 0, 0, 0);
    add(0, I_ADD, 1, 1, 3, X_EXEC,  4, 0, 0, 0);
    add(0, I_ADD, 1, 1, 4, X_WB,    0, 0, 0, 0);
    add(0, I_CMP, 1, 1, 1, X_FETCH, 0, 0, 0, 1);   // CMP
    add(0, I_CMP, 1, 1, 2, X_DEC,   0, 0, 0, 1);
    add(0, I_CMP, 1, 1, 3, X_CMPS,  4'hA, 0, 0, 1);
    add(0, I_CMP, 0, 1, 1, X_FETCH, 0, 0, 0, 2);   // cond-fail
    add(0, I_CMP, 0, 1, 1, X_FETCH, 0, 0, 0, 2);
    add(0, I_LDR, 1, 1, 1, X_FETCH, 0, 0, 0, 2);   // LDR
    add(0, I_LDR, 1, 1, 2, X_DEC,   0, 0, 0, 2);
    add(0, I_LDR, 1, 1, 5, X_MADDR, 4, 0, 0, 2);
    add(0, I_LDR, 1, 1, 6, X_MRD,   0, 0, 0, 2);
    add(0, I_LDR, 1, 1, 7, X_MWB,   0, 0, 0, 2);
    add(0, I_STR, 1, 1, 1, X_FETCH, 0, 0, 0, 3);   // STR, U=0
    add(0, I_STR, 1, 1, 2, X_DEC,   0, 0, 0, 3);
    add(0, I_STR, 1, 1, 5, X_MADDR, 2, 0, 0, 3);
    add(0, I_STR, 1, 1, 8, X_MWR,   0, 0, 0, 3);
    add(0, I_BL,  1, 1, 1, X_FETCH, 0, 0, 0, 4);   // BL
    add(0, I_BL,  1, 1, 2, X_DEC,   0, 0, 0, 4);
    add(0, I_BL,  1, 1, 9, X_BL,    0, 0, 0, 4);
    add(0, I_B,   1, 1, 1, X_FETCH, 0, 0, 0, 5);   // B
    add(0, I_B,   1, 1, 2, X_DEC,   0, 0, 0, 5);
    add(0, I_B,   1, 1, 9, X_B,     0, 0, 0, 5);
    add(0, I_ILL, 1, 1, 1, X_FETCH, 0, 0, 0, 6);   // illegal class
    add(0, I_ILL, 1, 1, 2, X_DEC,   0, 0, 0, 6);
    add(0, I_ADDS,1, 1, 1, X_FETCH, 0, 1, 0, 6);   // ADDS, halt at terminal
    add(0, I_ADDS,1, 1, 2, X_DEC,   0, 1, 0, 6);
    add(0, I_ADDS,1, 1, 3, X_EXECS, 4, 1, 0, 6);
    add(1, I_ADDS,1, 1, 4, X_WB,    0, 1, 0, 6);
    add(1, I_ADDS,0, 1, 0, X_NONE,  0, 1, 0, 7);
    add(0, I_ADDS,0, 1, 0, X_NONE,  0, 1, 0, 7);
    add(1, I_CMP, 0, 1, 1, X_FETCH, 0, 1, 0, 7);   // halt at cond-fail
    add(0, I_CMP, 0, 1, 0, X_NONE,  0, 1, 0, 7);
    add(1, I_CMP, 1, 1, 1, X_FETCH, 0, 1, 0, 7);   // halt ignored mid-instr
    add(1, I_CMP, 1, 1, 2, X_DEC,   0, 1, 0, 7);
    add(0, I_CMP, 1, 1, 3, X_CMPS,  4'hA, 1, 0, 7);
    add(0, I_CMP, 0, 1, 1, X_FETCH, 0, 1, 0, 8);
`ifdef CTRL_MEM_WAIT_EN
    add(0, I_LDR, 1, 1, 1, X_FETCH, 0, 1, 0, 8);   // LDR, 3 wait cycles
    add(0, I_LDR, 1, 1, 2, X_DEC,   0, 1, 0, 8);
    add(0, I_LDR, 1, 1, 5, X_MADDR, 4, 1, 0, 8);
    add(0, I_LDR, 1, 0, 6, X_MRD,   0, 1, 0, 8);
    add(0, I_LDR, 1, 0, 6, X_MRD,   0, 1, 0, 8);
    add(0, I_LDR, 1, 0, 6, X_MRD,   0, 1, 0, 8);
    add(0, I_LDR, 1, 1, 6, X_MRD,   0, 1, 0, 8);
    add(0, I_LDR, 1, 1, 7, X_MWB,   0, 1, 0, 8);
    add(0, I_LDR, 1, 1, 1, X_FETCH, 0, 1, 0, 9);   // LDR, timeout
    add(0, I_LDR, 1, 1, 2, X_DEC,   0, 1, 0, 9);
    add(0, I_LDR, 1, 0, 5, X_MADDR, 4, 1, 0, 9);
    for (int i = 0; i < 14; i++) add(0, I_LDR, 1, 0, 6, X_MRD, 0, 1, 0, 9);
    add(0, I_LDR, 0, 0, 6, X_MRDTO, 0, 1, 0, 9);
    add(0, I_STR, 1, 0, 1, X_FETCH, 0, 1, 1, 10);  // STR, one wait cycle
    add(0, I_STR, 1, 0, 2, X_DEC,   0, 1, 1, 10);
    add(0, I_STR, 1, 0, 5, X_MADDR, 2, 1, 1, 10);
    add(0, I_STR, 1, 0, 8, X_MWRW,  0, 1, 1, 10);
    add(0, I_STR, 1, 1, 8, X_MWR,   0, 1, 1, 10);
    add(0, I_STR, 0, 1, 1, X_FETCH, 0, 1, 1, 11);
    c0 = 16'd11;
    e0 = 1'b1;
`else
    add(0, I_LDR, 1, 0, 1, X_FETCH, 0, 1, 0, 8);   // mem_ready ignored
    add(0, I_LDR, 1, 0, 2, X_DEC,   0, 1, 0, 8);
    add(0, I_LDR, 1, 0, 5, X_MADDR, 4, 1, 0, 8);
    add(0, I_LDR, 1, 0, 6, X_MRD,   0, 1, 0, 8);
    add(0, I_LDR, 1, 0, 7, X_MWB,   0, 1, 0, 8);
    add(0, I_STR, 1, 0, 1, X_FETCH, 0, 1, 0, 9);
    add(0, I_STR, 1, 0, 2, X_DEC,   0, 1, 0, 9);
    add(0, I_STR, 1, 0, 5, X_MADDR, 2, 1, 0, 9);
    add(0, I_STR, 1, 0, 8, X_MWR,   0, 1, 0, 9);
    add(0, I_STR, 0, 0, 1, X_FETCH, 0, 1, 0, 10);
    c0 = 16'd10;
    e0 = 1'b0;
`endif
    add(0, I_ADD, 1, 1, 1, X_FETCH, 0, 1, e0, c0); // ADD, reset lands in EXEC
    add(0, I_ADD, 1, 1, 2, X_DEC,   0, 1, e0, c0);
    add(0, I_ADD, 1, 1, 3, X_EXEC,  4, 1, e0, c0);

    // ---- Reset state ----
    bus.halt = 1'b1; bus.IR = '0; bus.ir_valid = 1'b0; bus.mem_ready = 1'b1;
    bus4.halt = 1'b0; bus4.IR = I_B; bus4.ir_valid = 1'b1; bus4.mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check(900, sample(), zero);
    @(posedge clk);
    #1 rst = 1'b0;

    // ---- Table-driven run ----
    foreach (tbl[i]) apply(tbl[i], i);
    @(negedge clk);

    // ---- Asynchronous reset while in EXEC ----
    #2 rst = 1'b1;
    #1 check(901, sample(), zero);
    bus.IR = '0; bus.ir_valid = 1'b0; bus.halt = 1'b0;
    @(negedge clk);
    check(902, sample(), zero);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check(903, sample(), zero);                     // still IDLE before first edge
    @(negedge clk);
    check(904, sample(), '{st: 4'd1, stb: X_FETCH, alu: 4'h0, ill: 1'b0, err: 1'b0, cnt: 16'd0});

    // ---- ret_cnt wrap on a 4-bit instance running branches ----
    @(posedge clk);
    #1 rst4 = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        if (bus4.instr_done) seen = 1'b1;
      end
      check_val(1000 + k, {15'd0, seen}, 16'd1);
      @(negedge clk);
      check_val(1100 + k, {12'd0, bus4.ret_cnt}, {12'd0, 4'(k)});
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
